// File: rtl/neuron_mac_act.sv
// Sequential MAC neuron stage: accumulates signed 8x8 products, scales and saturates the
// sum into an 11-bit activation-LUT address, and captures the ROM result one read later.
module neuron_mac_act #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_w,
  input  logic        in_last,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic [7:0]  act_out,
  output logic        act_valid,
  output logic        busy
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;

  localparam logic signed [ACC_W-1:0] L_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] L_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] L_S_MAX   = ACC_W'(1023);
  localparam logic signed [ACC_W-1:0] L_S_MIN   = ACC_W'(-1024);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_SAT,
    S_ROMRD,
    S_CAP
  } state_t;

  state_t                    r_state, w_state_next;
  logic signed [ACC_W-1:0]   r_acc, w_acc_next;
  logic [ADDR_W-1:0]         r_rom_addr, w_rom_addr_next;
  logic [DATA_W-1:0]         r_act_out, w_act_out_next;
  logic                      r_act_valid, w_act_valid_next;

  logic                      w_accept;
  logic signed [PROD_W-1:0]  w_a_ext, w_w_ext, w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W:0]     w_sum;
  logic signed [ACC_W-1:0]   w_sum_sat;
  logic signed [ACC_W-1:0]   w_shr;
  logic [ADDR_W-1:0]         w_clamp;

  assign in_ready  = rst_n & ((r_state == S_IDLE) | (r_state == S_ACCUM));
  assign busy      = (r_state != S_IDLE);
  assign rom_addr  = r_rom_addr;
  assign act_out   = r_act_out;
  assign act_valid = r_act_valid;
  assign w_accept  = in_valid & in_ready;

  // Signed product and saturating accumulate (one extra sum bit detects overflow)
  assign w_a_ext    = {{(PROD_W-DATA_W){in_a[DATA_W-1]}}, in_a};
  assign w_w_ext    = {{(PROD_W-DATA_W){in_w[DATA_W-1]}}, in_w};
  assign w_prod     = w_a_ext * w_w_ext;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
  assign w_sum_sat  = (w_sum[ACC_W] != w_sum[ACC_W-1]) ?
                      (w_sum[ACC_W] ? L_ACC_MIN : L_ACC_MAX) : w_sum[ACC_W-1:0];

  // Scale and clamp to the signed 11-bit address range
  assign w_shr   = r_acc >>> SHIFT;
  assign w_clamp = (w_shr > L_S_MAX) ? 11'h3FF :
                   (w_shr < L_S_MIN) ? 11'h400 : w_shr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_rom_addr  <= '0;
      r_act_out   <= '0;
      r_act_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_rom_addr  <= w_rom_addr_next;
      r_act_out   <= w_act_out_next;
      r_act_valid <= w_act_valid_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_rom_addr_next  = r_rom_addr;
    w_act_out_next   = r_act_out;
    w_act_valid_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_next   = w_prod_ext;
          w_state_next = in_last ? S_SAT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_next   = w_sum_sat;
          w_state_next = in_last ? S_SAT : S_ACCUM;
        end
      end
      S_SAT: begin
        // Offset binary: adding 1024 to a signed 11-bit value flips its MSB
        w_rom_addr_next = {~w_clamp[ADDR_W-1], w_clamp[ADDR_W-2:0]};
        w_state_next    = S_ROMRD;
      end
      S_ROMRD: begin
        w_state_next = S_CAP;
      end
      S_CAP: begin
        w_act_out_next   = rom_q;
        w_act_valid_next = 1'b1;
        w_state_next     = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_neuron_mac_act.sv
// Directed bench for neuron_mac_act with a registered LUT ROM model (q = addr[10:3]).
module tb_neuron_mac_act;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready16;
  logic [7:0]  in_a, in_w;
  logic        in_last;
  logic [10:0] rom_addr, rom_addr16;
  logic [7:0]  rom_q, rom_q16;
  logic [7:0]  act_out, act_out16;
  logic        act_valid, act_valid16;
  logic        busy, busy16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  neuron_mac_act #(.ACC_W(24), .SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .rom_addr(rom_addr),
    .rom_q(rom_q), .act_out(act_out), .act_valid(act_valid), .busy(busy)
  );

  neuron_mac_act #(.ACC_W(16), .SHIFT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .rom_addr(rom_addr16),
    .rom_q(rom_q16), .act_out(act_out16), .act_valid(act_valid16), .busy(busy16)
  );

  always_ff @(posedge clk) begin
    rom_q   <= rom_addr[10:3];
    rom_q16 <= rom_addr16[10:3];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded wait on in_ready)
  task automatic send_beat(input int a, input int w, input logic last);
    int budget;
    in_a     = 8'(a);
    in_w     = 8'(w);
    in_last  = last;
    in_valid = 1'b1;
    budget   = 0;
    while (!in_ready && budget < 20) begin
      step();
      budget++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_a     = 8'hA5;
    in_w     = 8'h5A;
    in_last  = 1'b0;
  endtask

  // Called just after the edge that accepted the last beat
  task automatic tail(input string tag, input logic [10:0] exp_addr, input logic [7:0] exp_q);
    chk({tag, "_sat_busy"}, 32'(busy), 32'd1);
    chk({tag, "_sat_rdy"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, "_romrd_addr"}, 32'(rom_addr), 32'(exp_addr));
    chk({tag, "_romrd_vld"}, 32'(act_valid), 32'd0);
    chk({tag, "_romrd_rdy"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, "_cap_vld"}, 32'(act_valid), 32'd0);
    chk({tag, "_cap_rdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_cap_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_act_valid"}, 32'(act_valid), 32'd1);
    chk({tag, "_act_out"}, 32'(act_out), 32'(exp_q));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_w     = '0;
    in_last  = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_act_out", 32'(act_out), 32'd0);
    chk("rst_act_valid", 32'(act_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Single beat 16*16 = 256 -> s=16 -> addr 1040 -> q 0x82
    send_beat(16, 16, 1'b1);
    tail("t1", 11'd1040, 8'h82);
    step();
    chk("t1_pulse_end", 32'(act_valid), 32'd0);
    chk("t1_act_hold", 32'(act_out), 32'h82);

    // -128*127 = -16256 -> s=-1016 -> addr 8 -> q 0x01
    send_beat(-128, 127, 1'b1);
    tail("t2", 11'd8, 8'h01);

    // Positive address saturation
    send_beat(127, 127, 1'b0);
    send_beat(127, 127, 1'b1);
    tail("t3", 11'd2047, 8'hFF);

    // Negative address saturation
    send_beat(-128, 127, 1'b0);
    send_beat(-128, 127, 1'b1);
    tail("t4", 11'd0, 8'h00);

    // 4-beat vector with idle gaps: 100-100+9+200 = 209 -> s=13 -> addr 1037 -> q 0x81
    send_beat(10, 10, 1'b0);
    repeat (2) step();
    chk("t5_accum_rdy", 32'(in_ready), 32'd1);
    chk("t5_accum_busy", 32'(busy), 32'd1);
    send_beat(20, -5, 1'b0);
    send_beat(3, 3, 1'b0);
    repeat (3) step();
    chk("t5_gap_vld", 32'(act_valid), 32'd0);
    send_beat(100, 2, 1'b1);
    tail("t5", 11'd1037, 8'h81);

    // Back-to-back vector accepted in the act_valid cycle
    send_beat(16, 16, 1'b1);
    chk("t6_b2b_vld_end", 32'(act_valid), 32'd0);
    tail("t6", 11'd1040, 8'h82);

    // Accumulator clamp in the 16-bit instance: 32767 then 16511 -> s=1031 -> 2047
    send_beat(127, 127, 1'b0);
    send_beat(127, 127, 1'b0);
    send_beat(127, 127, 1'b0);
    send_beat(-128, 127, 1'b1);
    tail("t7", 11'd2047, 8'hFF);
    chk("t7_acc16_addr", 32'(rom_addr16), 32'd2047);
    chk("t7_acc16_vld", 32'(act_valid16), 32'd1);
    chk("t7_acc16_out", 32'(act_out16), 32'hFF);

    // Reset during ACCUM
    send_beat(16, 16, 1'b0);
    chk("t8_accum_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_busy", 32'(busy), 32'd0);
    chk("t8_rst_rdy", 32'(in_ready), 32'd0);
    chk("t8_rst_addr", 32'(rom_addr), 32'd0);
    chk("t8_rst_out", 32'(act_out), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Reset during ROMRD
    send_beat(16, 16, 1'b1);
    step();
    chk("t9_romrd_addr", 32'(rom_addr), 32'd1040);
    #2 rst_n = 1'b0;
    #1;
    chk("t9_rst_addr", 32'(rom_addr), 32'd0);
    chk("t9_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t9_no_pulse", 32'(act_valid), 32'd0);
    end
    chk("t9_out_reset", 32'(act_out), 32'd0);

    // Recovery after reset
    send_beat(16, 16, 1'b1);
    tail("t10", 11'd1040, 8'h82);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_mac_act.md
Name: neuron_mac_act

Overview:
- Sequential multiply-accumulate neuron stage that sits directly upstream of the activation-function LUT ROM.
- It accepts a stream of signed 8-bit activation/weight pairs over a valid/ready handshake and accumulates their products.
- It scales and saturates the final sum into the ROM's 11-bit address, issues the lookup, and captures the 8-bit ROM output as the neuron's activated result.
- It accounts for the ROM's one-cycle registered read latency.

Parameters:
- ACC_W, 24: signed accumulator width; legal range ACC_W >= SHIFT+11 and ACC_W >= 16.
- SHIFT, 4: arithmetic right shift applied to the final accumulator before address saturation.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  8  signed activation operand
- in_w  in  8  signed weight operand
- in_last  in  1  marks the final beat of a neuron's vector
- rom_addr  out  11  address to activation LUT ROM (registered)
- rom_q  in  8  ROM data; valid one clk after rom_addr is sampled
- act_out  out  8  captured activation result
- act_valid  out  1  one-cycle pulse: act_out updated
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ACCUM, SAT, ROMRD, CAP.
- in_ready = 1 in IDLE/ACCUM, 0 otherwise; forced 0 while rst_n low. A beat is accepted when in_valid && in_ready at a rising edge.
- Product: p = in_a*in_w as 16-bit signed, sign-extended to ACC_W.
- IDLE, beat accepted: acc <= p (load, not add). Next state is SAT if in_last, else ACCUM.
- ACCUM, beat accepted: acc <= sat_ACC(acc+p), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Next state is SAT if in_last, else stay. No beat: hold acc and stay; gaps are unlimited.
- SAT:
  - s = acc >>> SHIFT (arithmetic shift, floor rounding).
  - s clamped to [-1024, 1023].
  - rom_addr <= clamp + 1024, offset binary, i.e. MSB inverted.
  - Next state ROMRD.
- ROMRD: rom_addr held stable; ROM samples it at this edge. Next state CAP.
- CAP: act_out <= rom_q; act_valid <= 1 for exactly one cycle, coinciding with return to IDLE.
- Latency: with the last beat accepted at edge E, act_valid is high in the cycle after edge E+3 (4 edges). in_ready returns to 1 at edge E+3 (entry to IDLE), so a new vector's first beat can be accepted in the same cycle act_valid is high.
- Single-beat vector (in_last on the first beat) is legal; result uses that product alone.
- rom_addr and act_out hold their last values until overwritten; act_out is never changed outside CAP.
- Reset: state=IDLE, acc=0, rom_addr=0, act_out=0, act_valid=0, busy=0.
- Reset asserted mid-operation, in any state, abandons the vector immediately with no act_valid pulse.
- in_a/in_w/in_last are ignored when not accepted.

Test Plan:
Bench ROM model: 1-cycle registered read, q = addr[10:3].
- Single beat a=16, w=16, last → acc=256, s=16, rom_addr=1040, act_out=0x82, act_valid 4 edges after acceptance; busy high in between.
- Single beat a=-128, w=127, last → acc=-16256, s=-1016, rom_addr=8, act_out=0x01.
- Two beats a=127, w=127 → s=2016 saturates to 1023, rom_addr=2047, act_out=0xFF. Two beats a=-128, w=127 → s=-2032 saturates to -1024, rom_addr=0, act_out=0x00.
- 4-beat vector (a,w)=(10,10),(20,-5),(3,3),(100,2) with 0-3 idle cycles between beats → acc=209, s=13, rom_addr=1037, act_out=0x81. in_ready low from SAT through CAP. Second vector accepted in the act_valid cycle; result correct and independent of the first.
- ACC_W=16, beats (127,127)×3 then (-128,127), last → acc clamps to 32767 then becomes 16511, s=1031 saturates to 1023, rom_addr=2047, act_out=0xFF.
- rst_n pulsed low during ACCUM, and again during ROMRD → no act_valid, outputs back to reset values. Subsequent single beat a=16, w=16 → rom_addr=1040, act_out=0x82.
